traffic_lamp_driver: RTL
========================

Name: traffic_lamp_driver

Overview:
- Receiving end of the traffic-light control interface. It takes the one-cycle RED_EN / YELLOW_EN / GREEN_EN strobes from the light controller and turns them into held, one-hot lamp drive outputs.
- It checks that strobes arrive in the legal R->G->Y->R order and within the dwell limit.
- It latches pedestrian requests and issues a timed WALK during red.
- On any protocol violation it enters a latched FAULT state and reports a fault code.

Parameters:
- MAX_DWELL, 8: maximum cycles a lamp state may be held without a legal next strobe.
- WALK_CYCLES, 3: length of the WALK pulse, in cycles.
- BLINK_HALF, 2: half-period of the fault blink, in cycles (used only with the optional feature).
- CNT_W, 4: width of the dwell and walk counters. Must satisfy 2^CNT_W > MAX_DWELL, WALK_CYCLES and BLINK_HALF.

Ports:
- Clk, in, 1: system clock, rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- RED_EN, in, 1: red strobe from the controller.
- YELLOW_EN, in, 1: yellow strobe.
- GREEN_EN, in, 1: green strobe.
- Ped_Req, in, 1: pedestrian button, level or pulse; sampled every cycle.
- Clr_Fault, in, 1: clears the FAULT state.
- LAMP_R, out, 1: red lamp drive.
- LAMP_Y, out, 1: yellow lamp drive.
- LAMP_G, out, 1: green lamp drive.
- WALK, out, 1: pedestrian walk lamp.
- Ped_Pending, out, 1: a pedestrian request is latched and not yet served.
- Fault, out, 1: high while in FAULT.
- Fault_Code, out, 2: 0 = none, 1 = illegal order, 2 = multiple strobes, 3 = timeout.
- Dwell, out, CNT_W: cycles spent in the current lamp state.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State OFF.
  - All lamps 0, WALK 0, Ped_Pending 0, Fault 0, Fault_Code 0, Dwell 0.
- Timing:
  - All outputs are registered.
  - A strobe sampled at edge N is reflected in the lamp outputs after edge N (1-cycle latency).
- States: OFF, RED, GREEN, YELLOW, FAULT.
- Lamp outputs:
  - RED, GREEN and YELLOW each drive their own lamp one-hot.
  - OFF drives all lamps 0.
  - FAULT drives LAMP_R=1 with the other lamps 0 (see Optional Feature).
- Strobe count: the number of strobes high in the same cycle.
  - More than one -> FAULT, code 2. This check takes priority over all other checks.
- Legal transitions on a single strobe:
  - OFF + RED_EN -> RED
  - RED + GREEN_EN -> GREEN
  - GREEN + YELLOW_EN -> YELLOW
  - YELLOW + RED_EN -> RED
- Other strobes:
  - A strobe equal to the current colour is ignored: no state change, Dwell keeps counting.
  - Any other single strobe in OFF, RED, GREEN or YELLOW -> FAULT, code 1.
- Dwell counter:
  - Cleared to 0 on entry to any state.
  - Increments by 1 each cycle while in RED, GREEN or YELLOW.
  - Held at 0 in OFF and FAULT.
- Timeout:
  - In RED, GREEN or YELLOW, if Dwell==MAX_DWELL and no legal strobe is present -> FAULT, code 3.
  - A legal strobe sampled in the same cycle as Dwell==MAX_DWELL is accepted.
- FAULT behaviour:
  - FAULT is sticky and all strobes are ignored.
  - Clr_Fault=1 -> OFF, with Fault_Code reset to 0.
  - A strobe arriving in the same cycle as Clr_Fault is ignored.
  - Fault_Code holds the first fault cause until it is cleared.
- Pedestrian request:
  - Ped_Req=1 sets Ped_Pending. It stays set until served.
  - On entry to RED with Ped_Pending set (including a Ped_Req arriving in the same cycle as the RED strobe): WALK=1 for WALK_CYCLES cycles and Ped_Pending is cleared.
  - WALK drops immediately when leaving RED for any reason, including FAULT.
  - A request arriving while WALK=1 latches for the next red.
- FAULT and reset with pedestrians:
  - Entering FAULT forces WALK=0 and preserves Ped_Pending.
  - Reset mid-walk clears everything.

Optional Feature:
- Macro: LAMP_BLINK_EN.
- Defined: in FAULT, LAMP_R=0 and LAMP_Y toggles every BLINK_HALF cycles, starting at 1 on FAULT entry. The blink counter is cleared on exit.
- Not defined: FAULT drives a steady LAMP_R=1 and no blink counter is built.

Test Plan:
- Nominal cycle: strobes RED, then +5 cycles GREEN, then +5 cycles YELLOW, then +3 cycles RED.
  - Expect lamps R -> G -> Y -> R, each one cycle after its strobe.
  - Expect Dwell 4 just before each GREEN/YELLOW change, and Fault=0 throughout.
- Pedestrian: Ped_Req pulse during GREEN.
  - Expect Ped_Pending=1.
  - On the next RED: WALK=1 for exactly 3 cycles, and Ped_Pending=0 from the RED entry onward.
- Illegal order: in RED, pulse YELLOW_EN.
  - Expect Fault=1, Fault_Code=1, LAMP_R steady at 1.
  - Further strobes are ignored; Clr_Fault -> OFF with Fault_Code=0.
- Multiple strobes: in GREEN, assert RED_EN and YELLOW_EN together.
  - Expect Fault_Code=2, not 1.
- Timeout: RED strobe with no further strobes.
  - Expect FAULT with code 3 after the edge where Dwell=8.
  - Repeat with a GREEN strobe in the Dwell=8 cycle: expect GREEN and no fault.
- Reset mid-walk: assert Reset_n=0 while WALK=1.
  - Expect all outputs to go to 0 immediately, asynchronously.
  - With LAMP_BLINK_EN defined, a separate FAULT run shows LAMP_Y at 1,1,0,0,1,…

Source files
------------

// File: rtl/traffic_lamp_driver.sv
// Traffic lamp driver: checks controller strobe order/dwell, holds lamps, times WALK.
// Optional fault blink on LAMP_Y when LAMP_BLINK_EN is defined.
module traffic_lamp_driver #(
    parameter int MAX_DWELL   = 8,
    parameter int WALK_CYCLES = 3,
    parameter int BLINK_HALF  = 2,
    parameter int CNT_W       = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             RED_EN,
    input  logic             YELLOW_EN,
    input  logic             GREEN_EN,
    input  logic             Ped_Req,
    input  logic             Clr_Fault,
    output logic             LAMP_R,
    output logic             LAMP_Y,
    output logic             LAMP_G,
    output logic             WALK,
    output logic             Ped_Pending,
    output logic             Fault,
    output logic [1:0]       Fault_Code,
    output logic [CNT_W-1:0] Dwell
);

    typedef enum logic [2:0] {
        S_OFF,
        S_RED,
        S_GREEN,
        S_YELLOW,
        S_FAULT
    } state_t;

    if ((2 ** CNT_W) <= MAX_DWELL
        || (2 ** CNT_W) <= WALK_CYCLES
        || (2 ** CNT_W) <= BLINK_HALF) begin : g_bad_cnt_w
        $error("CNT_W too narrow for counters");
    end

    state_t           r_state;
    logic [1:0]       r_code;
    logic             r_fault;
    logic [CNT_W-1:0] r_dwell;
    logic             r_lamp_r;
    logic             r_lamp_y;
    logic             r_lamp_g;
    logic             r_walk;
    logic [CNT_W-1:0] r_walk_cnt;
    logic             r_ped;
`ifdef LAMP_BLINK_EN
    logic [CNT_W-1:0] r_blink;
`endif

    logic [1:0] w_nstb;
    logic       w_legal;
    logic       w_same;
    state_t     w_tgt;
    state_t     w_nxt;
    logic [1:0] w_code;
    logic       w_enter_red;

    assign w_nstb = {1'b0, RED_EN}
                  + {1'b0, YELLOW_EN}
                  + {1'b0, GREEN_EN};

    always_comb begin
        w_legal = 1'b0;
        w_same  = 1'b0;
        w_tgt   = r_state;
        unique case (r_state)
            S_OFF: begin
                w_legal = RED_EN;
                w_tgt   = S_RED;
            end
            S_RED: begin
                w_legal = GREEN_EN;
                w_same  = RED_EN;
                w_tgt   = S_GREEN;
            end
            S_GREEN: begin
                w_legal = YELLOW_EN;
                w_same  = GREEN_EN;
                w_tgt   = S_YELLOW;
            end
            S_YELLOW: begin
                w_legal = RED_EN;
                w_same  = YELLOW_EN;
                w_tgt   = S_RED;
            end
            default: ;
        endcase
    end

    // Multi-strobe beats order, order beats timeout; FAULT ignores strobes.
    always_comb begin
        w_nxt  = r_state;
        w_code = r_code;
        if (r_state == S_FAULT) begin
            if (Clr_Fault) begin
                w_nxt  = S_OFF;
                w_code = 2'd0;
            end
        end else if (w_nstb > 2'd1) begin
            w_nxt  = S_FAULT;
            w_code = 2'd2;
        end else if (w_legal) begin
            w_nxt = w_tgt;
        end else if (w_nstb != 2'd0 && !w_same) begin
            w_nxt  = S_FAULT;
            w_code = 2'd1;
        end else if (r_state != S_OFF
                     && r_dwell == CNT_W'(MAX_DWELL)) begin
            w_nxt  = S_FAULT;
            w_code = 2'd3;
        end
    end

    assign w_enter_red = (w_nxt == S_RED) && (r_state != S_RED);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_OFF;
            r_code     <= 2'd0;
            r_fault    <= 1'b0;
            r_dwell    <= '0;
            r_lamp_r   <= 1'b0;
            r_lamp_y   <= 1'b0;
            r_lamp_g   <= 1'b0;
            r_walk     <= 1'b0;
            r_walk_cnt <= '0;
            r_ped      <= 1'b0;
`ifdef LAMP_BLINK_EN
            r_blink    <= '0;
`endif
        end else begin
            r_state  <= w_nxt;
            r_code   <= w_code;
            r_fault  <= (w_nxt == S_FAULT);
            if (w_nxt != r_state || w_nxt == S_OFF
                || w_nxt == S_FAULT)
                r_dwell <= '0;
            else
                r_dwell <= r_dwell + 1'b1;

            r_lamp_r <= (w_nxt == S_RED);
            r_lamp_y <= (w_nxt == S_YELLOW);
            r_lamp_g <= (w_nxt == S_GREEN);
`ifdef LAMP_BLINK_EN
            if (w_nxt == S_FAULT) begin
                if (r_state != S_FAULT) begin
                    r_lamp_y <= 1'b1;
                    r_blink  <= '0;
                end else if (r_blink == CNT_W'(BLINK_HALF - 1)) begin
                    r_lamp_y <= ~r_lamp_y;
                    r_blink  <= '0;
                end else begin
                    r_lamp_y <= r_lamp_y;
                    r_blink  <= r_blink + 1'b1;
                end
            end else begin
                r_blink <= '0;
            end
`else
            if (w_nxt == S_FAULT)
                r_lamp_r <= 1'b1;
`endif

            // A request in the RED-entry cycle is served by this walk.
            r_ped <= r_ped | Ped_Req;
            if (w_enter_red) begin
                if (r_ped || Ped_Req) begin
                    r_walk     <= 1'b1;
                    r_walk_cnt <= CNT_W'(WALK_CYCLES - 1);
                    r_ped      <= 1'b0;
                end else begin
                    r_walk <= 1'b0;
                end
            end else if (w_nxt != S_RED) begin
                r_walk <= 1'b0;
            end else if (r_walk) begin
                if (r_walk_cnt == '0)
                    r_walk <= 1'b0;
                else
                    r_walk_cnt <= r_walk_cnt - 1'b1;
            end
        end
    end

    assign LAMP_R      = r_lamp_r;
    assign LAMP_Y      = r_lamp_y;
    assign LAMP_G      = r_lamp_g;
    assign WALK        = r_walk;
    assign Ped_Pending = r_ped;
    assign Fault       = r_fault;
    assign Fault_Code  = r_code;
    assign Dwell       = r_dwell;

endmodule
